// File: rtl/mips_core_pkg.sv
// mips_core_pkg: types shared by the out-of-order core blocks.
//   PREG_W         physical register tag width
//   ActiveListIdx  index into the default 32-entry active list
//   ALState        active list control states (normal / rollback / end-of-flush)
package mips_core_pkg;

   localparam int PREG_W   = 6;
   localparam int AL_DEPTH = 32;
   localparam int AL_IDX_W = $clog2(AL_DEPTH);

   typedef logic [AL_IDX_W-1:0] ActiveListIdx;

   typedef enum logic [1:0] {
      AL_NORMAL   = 2'd0,
      AL_ROLLBACK = 2'd1,
      AL_END      = 2'd2
   } ALState;

endpackage

// File: rtl/active_list.sv
// active_list: in-order circular buffer of renamed instructions.
//   Dispatch allocates the tail entry, completion marks entries done, the head
//   retires in order once done, and a flush walks the tail back one entry per
//   cycle, reporting each discarded entry so the rename map can be restored.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   disp_valid/disp_ready      dispatch handshake; disp_* payload
//   alloc_index                index handed to the dispatching instruction
//   done_valid/done_index      execution completion of one entry
//   commit_*                   registered retirement of the head entry
//   flush_valid/flush_index    mispredicted entry; younger entries discarded
//   rb_*                       registered report of one rolled-back entry
//   end_flush                  one-cycle pulse when rollback has finished
//   count                      number of occupied entries
module active_list #(
   parameter int DEPTH  = 32,
   parameter int PREG_W = 6,
   parameter int ID_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic                       disp_uses_rw,
   input  logic [4:0]                 disp_arch_rw,
   input  logic [PREG_W-1:0]          disp_new_preg,
   input  logic [PREG_W-1:0]          disp_old_preg,
   input  logic [ID_W-1:0]            disp_id,
   output logic [$clog2(DEPTH)-1:0]   alloc_index,
   input  logic                       done_valid,
   input  logic [$clog2(DEPTH)-1:0]   done_index,
   output logic                       commit_valid,
   output logic                       commit_uses_rw,
   output logic [PREG_W-1:0]          commit_old_preg,
   output logic [ID_W-1:0]            commit_id,
   input  logic                       flush_valid,
   input  logic [$clog2(DEPTH)-1:0]   flush_index,
   output logic                       rb_valid,
   output logic                       rb_uses_rw,
   output logic [4:0]                 rb_arch_rw,
   output logic [PREG_W-1:0]          rb_old_preg,
   output logic [PREG_W-1:0]          rb_new_preg,
   output logic                       end_flush,
   output logic [$clog2(DEPTH):0]     count
);

   import mips_core_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   ALState             state_reg;
   logic [IDX_W-1:0]   head_reg;
   logic [IDX_W-1:0]   tail_reg;
   logic [IDX_W-1:0]   stop_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [DEPTH-1:0]   done_reg;

   // Entry payload; no reset needed, every entry is written before it is read.
   logic               uses_rw_mem  [DEPTH];
   logic [4:0]         arch_rw_mem  [DEPTH];
   logic [PREG_W-1:0]  new_preg_mem [DEPTH];
   logic [PREG_W-1:0]  old_preg_mem [DEPTH];
   logic [ID_W-1:0]    id_mem       [DEPTH];

   logic               disp_fire;
   logic               commit_fire;
   logic               done_hit;
   logic [IDX_W-1:0]   done_off;
   logic [IDX_W-1:0]   tail_dec;

   // A flush in the same cycle wins over dispatch, so ready drops with it.
   // Ready looks at the pre-commit count: a full list cannot accept an entry
   // even when the head retires in the same cycle.
   assign disp_ready  = (state_reg == AL_NORMAL) && (count_reg < FULL) && !flush_valid;
   assign disp_fire   = disp_valid && disp_ready;
   assign commit_fire = (state_reg == AL_NORMAL) && !flush_valid &&
                        (count_reg != '0) && done_reg[head_reg];

   // An entry is occupied when its distance from the head is below count;
   // completions for free (or already rolled-back) slots are dropped.
   assign done_off = done_index - head_reg;
   assign done_hit = done_valid && ({1'b0, done_off} < count_reg);

   assign tail_dec    = tail_reg - IDX_W'(1);
   assign alloc_index = tail_reg;
   assign count       = count_reg;

   always_ff @(posedge clk) begin
      if (disp_fire) begin
         uses_rw_mem[tail_reg]  <= disp_uses_rw;
         arch_rw_mem[tail_reg]  <= disp_arch_rw;
         new_preg_mem[tail_reg] <= disp_new_preg;
         old_preg_mem[tail_reg] <= disp_old_preg;
         id_mem[tail_reg]       <= disp_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= AL_NORMAL;
         head_reg        <= '0;
         tail_reg        <= '0;
         stop_reg        <= '0;
         count_reg       <= '0;
         done_reg        <= '0;
         commit_valid    <= 1'b0;
         commit_uses_rw  <= 1'b0;
         commit_old_preg <= '0;
         commit_id       <= '0;
         rb_valid        <= 1'b0;
         rb_uses_rw      <= 1'b0;
         rb_arch_rw      <= '0;
         rb_old_preg     <= '0;
         rb_new_preg     <= '0;
         end_flush       <= 1'b0;
      end else begin
         commit_valid <= 1'b0;
         rb_valid     <= 1'b0;
         end_flush    <= 1'b0;

         // Completion is honoured in every state, including the flush cycle.
         if (done_hit) begin
            done_reg[done_index] <= 1'b1;
         end

         case (state_reg)
            AL_NORMAL: begin
               if (flush_valid) begin
                  state_reg <= AL_ROLLBACK;
                  stop_reg  <= flush_index + IDX_W'(1);
               end else begin
                  if (disp_fire) begin
                     done_reg[tail_reg] <= 1'b0;
                     tail_reg           <= tail_reg + IDX_W'(1);
                  end
                  if (commit_fire) begin
                     commit_valid    <= 1'b1;
                     commit_uses_rw  <= uses_rw_mem[head_reg];
                     commit_old_preg <= old_preg_mem[head_reg];
                     commit_id       <= id_mem[head_reg];
                     head_reg        <= head_reg + IDX_W'(1);
                  end
                  count_reg <= count_reg + CNT_W'(disp_fire) - CNT_W'(commit_fire);
               end
            end

            // Discard youngest first until the tail sits just past the
            // mispredicted entry.
            AL_ROLLBACK: begin
               if (tail_reg != stop_reg) begin
                  tail_reg    <= tail_dec;
                  count_reg   <= count_reg - CNT_W'(1);
                  rb_valid    <= 1'b1;
                  rb_uses_rw  <= uses_rw_mem[tail_dec];
                  rb_arch_rw  <= arch_rw_mem[tail_dec];
                  rb_old_preg <= old_preg_mem[tail_dec];
                  rb_new_preg <= new_preg_mem[tail_dec];
               end else begin
                  state_reg <= AL_END;
                  end_flush <= 1'b1;
               end
            end

            AL_END: begin
               state_reg <= AL_NORMAL;
            end

            default: begin
               state_reg <= AL_NORMAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_active_list.sv
// tb_active_list: directed stimulus with a queue-based scoreboard for the
// active list. Stimulus pushes expected commit / rollback / end_flush events;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_active_list;

   localparam int DEPTH  = 32;
   localparam int PREG_W = 6;
   localparam int ID_W   = 32;
   localparam int IDX_W  = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              disp_valid = 1'b0;
   logic              disp_ready;
   logic              disp_uses_rw = 1'b0;
   logic [4:0]        disp_arch_rw = '0;
   logic [PREG_W-1:0] disp_new_preg = '0;
   logic [PREG_W-1:0] disp_old_preg = '0;
   logic [ID_W-1:0]   disp_id = '0;
   logic [IDX_W-1:0]  alloc_index;
   logic              done_valid = 1'b0;
   logic [IDX_W-1:0]  done_index = '0;
   logic              commit_valid;
   logic              commit_uses_rw;
   logic [PREG_W-1:0] commit_old_preg;
   logic [ID_W-1:0]   commit_id;
   logic              flush_valid = 1'b0;
   logic [IDX_W-1:0]  flush_index = '0;
   logic              rb_valid;
   logic              rb_uses_rw;
   logic [4:0]        rb_arch_rw;
   logic [PREG_W-1:0] rb_old_preg;
   logic [PREG_W-1:0] rb_new_preg;
   logic              end_flush;
   logic [IDX_W:0]    count;

   active_list #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_uses_rw(disp_uses_rw), .disp_arch_rw(disp_arch_rw),
      .disp_new_preg(disp_new_preg), .disp_old_preg(disp_old_preg),
      .disp_id(disp_id), .alloc_index(alloc_index),
      .done_valid(done_valid), .done_index(done_index),
      .commit_valid(commit_valid), .commit_uses_rw(commit_uses_rw),
      .commit_old_preg(commit_old_preg), .commit_id(commit_id),
      .flush_valid(flush_valid), .flush_index(flush_index),
      .rb_valid(rb_valid), .rb_uses_rw(rb_uses_rw), .rb_arch_rw(rb_arch_rw),
      .rb_old_preg(rb_old_preg), .rb_new_preg(rb_new_preg),
      .end_flush(end_flush), .count(count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int   id;
      int   old_preg;
      int   uses;
      int   at;      // expected cycle, -1 when timing is not checked
   } commit_t;

   typedef struct {
      int   uses;
      int   arch;
      int   old_preg;
      int   new_preg;
      int   at;
   } rb_t;

   commit_t exp_commit[$];
   rb_t     exp_rb[$];
   int      exp_end[$];

   function automatic void chk(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
      end
   endfunction

   function automatic void unexpected(string name, longint act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got event value %0d expected no event (cycle %0d)", name, act, cyc);
   endfunction

   // Monitor: every DUT output event is matched against the scoreboard.
   always @(negedge clk) begin
      if (commit_valid) begin
         if (exp_commit.size() == 0) begin
            unexpected("unexpected_commit", commit_id);
         end else begin
            commit_t e;
            e = exp_commit.pop_front();
            chk("commit_id", commit_id, e.id);
            chk("commit_old_preg", commit_old_preg, e.old_preg);
            chk("commit_uses_rw", commit_uses_rw, e.uses);
            if (e.at >= 0) chk("commit_cycle", cyc, e.at);
         end
      end
      if (rb_valid) begin
         if (exp_rb.size() == 0) begin
            unexpected("unexpected_rb", rb_new_preg);
         end else begin
            rb_t r;
            r = exp_rb.pop_front();
            chk("rb_uses_rw", rb_uses_rw, r.uses);
            chk("rb_arch_rw", rb_arch_rw, r.arch);
            chk("rb_old_preg", rb_old_preg, r.old_preg);
            chk("rb_new_preg", rb_new_preg, r.new_preg);
            if (r.at >= 0) chk("rb_cycle", cyc, r.at);
         end
      end
      if (end_flush) begin
         if (exp_end.size() == 0) begin
            unexpected("unexpected_end_flush", 1);
         end else begin
            int at;
            at = exp_end.pop_front();
            chk("end_flush_cycle", cyc, at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      disp_valid  = 1'b0;
      done_valid  = 1'b0;
      flush_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_count", count, 0);
      chk("rst_alloc_index", alloc_index, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_rb_valid", rb_valid, 0);
      chk("rst_end_flush", end_flush, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_disp_ready", disp_ready, 1);
   endtask

   task automatic dispatch(input int id, input int arch, input int newp,
                           input int oldp, input int uses);
      chk("disp_ready", disp_ready, 1);
      disp_valid    = 1'b1;
      disp_id       = ID_W'(id);
      disp_arch_rw  = 5'(arch);
      disp_new_preg = PREG_W'(newp);
      disp_old_preg = PREG_W'(oldp);
      disp_uses_rw  = 1'(uses);
      tick();
   endtask

   task automatic mark_done(input int idx);
      done_valid = 1'b1;
      done_index = IDX_W'(idx);
      tick();
   endtask

   task automatic push_commit(input int id, input int oldp, input int uses, input int at);
      commit_t e;
      e.id = id; e.old_preg = oldp; e.uses = uses; e.at = at;
      exp_commit.push_back(e);
   endtask

   task automatic push_rb(input int uses, input int arch, input int oldp,
                          input int newp, input int at);
      rb_t r;
      r.uses = uses; r.arch = arch; r.old_preg = oldp; r.new_preg = newp; r.at = at;
      exp_rb.push_back(r);
   endtask

   // Bounded wait for the scoreboard to empty, then idle to catch extras.
   task automatic drain();
      int budget;
      budget = 300;
      while ((exp_commit.size() + exp_rb.size() + exp_end.size()) != 0 && budget > 0) begin
         tick();
         budget--;
      end
      if ((exp_commit.size() + exp_rb.size() + exp_end.size()) != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending events expected 0",
                  exp_commit.size() + exp_rb.size() + exp_end.size());
      end
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int f;
      do_reset();

      // In-order commit despite out-of-order completion.
      dispatch(0, 1, 10, 20, 1);
      dispatch(1, 2, 11, 21, 0);
      dispatch(2, 3, 12, 22, 1);
      chk("t1_count", count, 3);
      chk("t1_alloc_index", alloc_index, 3);
      mark_done(2);
      mark_done(0);
      push_commit(0, 20, 1, cyc + 1);
      push_commit(1, 21, 0, cyc + 2);
      push_commit(2, 22, 1, cyc + 3);
      mark_done(1);
      drain();
      chk("t1_count_end", count, 0);

      // Fill to DEPTH from head 3; full list refuses dispatch even with a commit.
      for (int i = 0; i < 32; i++) dispatch(100 + i, (i + 3) % 32, i, 63 - i, i % 2);
      chk("full_disp_ready", disp_ready, 0);
      chk("full_count", count, 32);
      chk("full_alloc_index", alloc_index, 3);
      disp_valid = 1'b1;
      disp_id    = 999;
      tick();
      chk("full_count_hold", count, 32);
      push_commit(100, 63, 0, cyc + 2);
      mark_done(3);
      chk("full_commit_cycle_ready", disp_ready, 0);
      chk("full_commit_cycle_count", count, 32);
      tick();
      chk("after_commit_count", count, 31);
      chk("after_commit_ready", disp_ready, 1);
      for (int i = 1; i < 32; i++) begin
         push_commit(100 + i, 63 - i, i % 2, -1);
         mark_done((3 + i) % 32);
      end
      drain();
      chk("full_drained_count", count, 0);

      // Advance head to 30.
      for (int i = 0; i < 27; i++) begin
         dispatch(200 + i, i % 32, i % 64, (i + 7) % 64, 1);
         push_commit(200 + i, (i + 7) % 64, 1, -1);
         mark_done((3 + i) % 32);
      end
      drain();
      chk("head30_alloc_index", alloc_index, 30);

      // Pointer wrap.
      for (int i = 0; i < 4; i++) begin
         chk("wrap_alloc_index", alloc_index, (30 + i) % 32);
         dispatch(300 + i, i, 30 + i, 40 + i, i % 2);
      end
      chk("wrap_count", count, 4);
      for (int i = 0; i < 4; i++) push_commit(300 + i, 40 + i, i % 2, -1);
      mark_done(31);
      mark_done(1);
      mark_done(0);
      mark_done(30);
      drain();
      chk("wrap_alloc_end", alloc_index, 2);
      chk("wrap_count_end", count, 0);

      // Rollback of entries 5,4,3 after flush at 2.
      do_reset();
      for (int i = 0; i < 6; i++) dispatch(400 + i, i + 1, 40 + i, 20 + i, i % 2);
      flush_valid = 1'b1;
      flush_index = 2;
      done_valid  = 1'b1;
      done_index  = 0;
      disp_valid  = 1'b1;
      disp_id     = 999;
      f = cyc + 1;
      push_rb(1, 6, 25, 45, f + 1);
      push_rb(0, 5, 24, 44, f + 2);
      push_rb(1, 4, 23, 43, f + 3);
      exp_end.push_back(f + 4);
      push_commit(400, 20, 0, f + 6);
      tick();
      chk("flush_count_no_disp", count, 6);
      tick();
      chk("rollback_disp_ready", disp_ready, 0);
      done_valid  = 1'b1;
      done_index  = 4;
      flush_valid = 1'b1;
      flush_index = 0;
      tick();
      tick();
      tick();
      tick();
      chk("rollback_cycle", cyc, f + 5);
      chk("rollback_count", count, 3);
      chk("rollback_tail", alloc_index, 3);
      drain();
      push_commit(401, 21, 1, -1);
      push_commit(402, 22, 0, -1);
      mark_done(1);
      mark_done(2);
      drain();
      chk("rollback_drained", count, 0);

      // Flush at the youngest entry: no rollback, single end_flush pulse.
      dispatch(500, 7, 50, 51, 1);
      dispatch(501, 8, 52, 53, 0);
      flush_valid = 1'b1;
      flush_index = 4;
      f = cyc + 1;
      exp_end.push_back(f + 1);
      tick();
      flush_valid = 1'b1;
      flush_index = 3;
      tick();
      chk("yflush_count", count, 2);
      chk("yflush_tail", alloc_index, 5);
      tick();
      chk("yflush_end_low", end_flush, 0);
      push_commit(500, 51, 1, -1);
      push_commit(501, 53, 0, -1);
      mark_done(3);
      mark_done(4);
      drain();
      chk("yflush_drained", count, 0);

      // Reset in the middle of a rollback.
      for (int i = 0; i < 4; i++) dispatch(600 + i, 9 + i, 50 + i, 30 + i, 1);
      flush_valid = 1'b1;
      flush_index = 5;
      f = cyc + 1;
      push_rb(1, 12, 33, 53, f + 1);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_count", count, 0);
      chk("midrst_rb_valid", rb_valid, 0);
      chk("midrst_alloc", alloc_index, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("midrst_end_flush", end_flush, 0);
      chk("midrst_count_after", count, 0);

      chk("left_commits", exp_commit.size(), 0);
      chk("left_rb", exp_rb.size(), 0);
      chk("left_end", exp_end.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/active_list.md
ACTIVE_LIST -- requirements
Module: active_list

Interface
REQ-001 SHALL have parameters: DEPTH, 32, number of in-order entries (power of 2); PREG_W, 6, physical register tag width; ID_W, 32, instruction ID width.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 disp_valid  input  1  renamed instruction offered for allocation.
REQ-005 disp_ready  output  1  entry available and not flushing.
REQ-006 disp_uses_rw / disp_arch_rw / disp_new_preg / disp_old_preg / disp_id  input  1/5/PREG_W/PREG_W/ID_W  destination-use flag, arch dest, new tag, previous mapping, instruction ID.
REQ-007 alloc_index  output  log2(DEPTH)  index given to the dispatched instruction (current tail), combinational.
REQ-008 done_valid / done_index  input  1 / log2(DEPTH)  execution completion of one entry.
REQ-009 commit_valid / commit_uses_rw / commit_old_preg / commit_id  output  1/1/PREG_W/ID_W  head retired this cycle; old_preg returns to free list.
REQ-010 flush_valid / flush_index  input  1 / log2(DEPTH)  mispredicted entry; all younger entries discarded.
REQ-011 rb_valid / rb_uses_rw / rb_arch_rw / rb_old_preg / rb_new_preg  output  1/1/5/PREG_W/PREG_W  one rolled-back entry: restore map arch_rw->old_preg, free new_preg.
REQ-012 end_flush  output  1  one-cycle pulse: rollback complete, instruction queue may resume adding.
REQ-013 count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL be a circular buffer with head, tail pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0, plus count of log2(DEPTH)+1 bits.
REQ-015 SHALL implement states NORMAL, ROLLBACK, END.
REQ-016 Dispatch SHALL occur when disp_valid && disp_ready; entry written at tail with done=0, tail+1, count+1.
REQ-017 disp_ready SHALL be 1 only in NORMAL with count < DEPTH.
REQ-018 done_valid SHALL set done of done_index only if that entry is occupied; otherwise ignored.
REQ-019 Commit SHALL occur in NORMAL when count>0 and head entry done=1 (including done set in a previous cycle); commit outputs registered, valid one cycle after qualifying, head+1, count-1; max one commit per cycle.
REQ-020 Simultaneous dispatch and commit SHALL leave count unchanged; dispatch at full with concurrent commit SHALL NOT be allowed (disp_ready uses pre-commit count).
REQ-021 flush_valid in NORMAL SHALL move to ROLLBACK, latch stop = flush_index+1 (mod DEPTH); same-cycle dispatch and commit suppressed; same-cycle done_valid still applied.
REQ-022 In ROLLBACK each cycle with tail != stop: tail-1, count-1, rb_* registered from entry at new tail, rb_valid=1 next cycle.
REQ-023 When tail == stop in ROLLBACK: go to END; END drives end_flush=1 for exactly one cycle, then NORMAL.
REQ-024 flush with no younger entries (tail == stop) SHALL pass ROLLBACK in one cycle with no rb_valid, end_flush two cycles after flush.
REQ-025 flush_valid in ROLLBACK or END SHALL be ignored; done_valid during ROLLBACK for discarded entries SHALL have no effect.
REQ-026 No commit during ROLLBACK/END.

Reset
REQ-027 On rst_n=0 at posedge: head=tail=0, count=0, all done=0, state NORMAL, commit_valid=rb_valid=end_flush=0, other outputs 0; reset mid-rollback abandons rollback with no further rb_valid.

Structure
REQ-028 ALState enum, PREG_W, ActiveListIdx typedef SHALL reside in mips_core_pkg.
REQ-029 Entry storage SHALL be a flat register array; no sub-module; pointer logic inline.

Verification
REQ-030 Reset, dispatch 3 (ids 0,1,2), done order 2,0,1 -> commits ids 0,1,2 in order, last cycle after done(1)+1.
REQ-031 Dispatch 32 without completion -> disp_ready=0, count=32; done head -> commit, disp_ready=1 next cycle.
REQ-032 Head at 30, dispatch 4 (indices 30,31,0,1) -> alloc_index wraps, commits wrap in order.
REQ-033 Entries 0..5, flush_index=2 -> rb_valid 3 cycles for entries 5,4,3 (youngest first), end_flush one cycle later, tail=3, count=3.
REQ-034 Flush at youngest entry -> no rb_valid, end_flush single pulse; second flush during ROLLBACK ignored.
REQ-035 rst_n=0 during ROLLBACK -> next cycle count=0, rb_valid=0, end_flush never asserted.
